// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush-to-bubble and a
// saturating stall counter. All outputs come straight from flops.
module pipe_stage_skid_reg #(
  parameter int DATA_W            = 64,
  parameter int CTRL_W            = 8,
  parameter int CLR_DATA_ON_FLUSH = 0,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              m_vld_q, m_vld_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              s_vld_q, s_vld_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // in_ready depends only on registered state, so no ready path runs through the stage
  assign in_ready  = (state_q != ST_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_vld_q & out_ready;

  assign out_valid = m_vld_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d  = state_q;
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_vld_d  = s_vld_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d  = ST_ONE;
          m_vld_d  = 1'b1;
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (in_fire) begin
          state_d  = ST_FULL;
          s_vld_d  = 1'b1;
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end else if (out_fire) begin
          // ctrl is cleared on drain so an empty stage always presents a bubble
          state_d  = ST_EMPTY;
          m_vld_d  = 1'b0;
          m_ctrl_d = '0;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d  = ST_ONE;
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          s_vld_d  = 1'b0;
          s_ctrl_d = '0;
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        m_vld_d  = 1'b0;
        m_ctrl_d = '0;
        s_vld_d  = 1'b0;
        s_ctrl_d = '0;
      end
    endcase

    // Flush wins over any simultaneous transfer; the incoming word is dropped
    if (flush) begin
      state_d  = ST_EMPTY;
      m_vld_d  = 1'b0;
      m_ctrl_d = '0;
      s_vld_d  = 1'b0;
      s_ctrl_d = '0;
      if (CLR_DATA_ON_FLUSH != 0) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)
      stall_cnt_d = '0;
    else if (m_vld_q && !out_ready)
      stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      m_vld_q     <= 1'b0;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_vld_q     <= 1'b0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_vld_q     <= m_vld_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_vld_q     <= s_vld_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: two instances share stimulus, one keeping stale
// data on flush with a 16-bit stall counter, one clearing data with a 3-bit counter.
module tb_pipe_stage_skid_reg;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          stall_clr = 1'b0;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall;

  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [CW-1:0] b_out_ctrl;
  logic [1:0]    b_occ;
  logic [2:0]    b_stall;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA_ON_FLUSH(0), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ), .stall_cnt(a_stall),
    .stall_clr(stall_clr)
  );

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CLR_DATA_ON_FLUSH(1), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occ), .stall_cnt(b_stall),
    .stall_clr(stall_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the state shared by both instances (data is checked separately where they differ)
  task automatic chk_both(input string tag, input logic vld, input logic [CW-1:0] ctrl,
                          input logic [1:0] occ, input logic rdy);
    chk({tag, " a.out_valid"}, 32'(a_out_valid), 32'(vld));
    chk({tag, " a.out_ctrl"},  32'(a_out_ctrl),  32'(ctrl));
    chk({tag, " a.occupancy"}, 32'(a_occ),       32'(occ));
    chk({tag, " a.in_ready"},  32'(a_in_ready),  32'(rdy));
    chk({tag, " b.out_valid"}, 32'(b_out_valid), 32'(vld));
    chk({tag, " b.out_ctrl"},  32'(b_out_ctrl),  32'(ctrl));
    chk({tag, " b.occupancy"}, 32'(b_occ),       32'(occ));
    chk({tag, " b.in_ready"},  32'(b_in_ready),  32'(rdy));
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] da, input logic [DW-1:0] db);
    chk({tag, " a.out_data"}, 32'(a_out_data), 32'(da));
    chk({tag, " b.out_data"}, 32'(b_out_data), 32'(db));
  endtask

  task automatic chk_stall(input string tag, input int sa, input int sb);
    chk({tag, " a.stall_cnt"}, 32'(a_stall), 32'(sa));
    chk({tag, " b.stall_cnt"}, 32'(b_stall), 32'(sb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, observed while rst is still low
    #1;
    chk_both("reset", 1'b0, 8'h00, 2'd0, 1'b1);
    chk_data("reset", 16'h0, 16'h0);
    chk_stall("reset", 0, 0);
    tick();
    tick();
    #3 rst = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      in_ctrl = CW'(8'h10 + i);
      tick();
      chk_both("stream", 1'b1, CW'(8'h10 + i), 2'd1, 1'b1);
      chk_data("stream", DW'(i), DW'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_both("stream drain", 1'b0, 8'h00, 2'd0, 1'b1);
    chk_stall("stream", 0, 0);

    // Back-pressure: A, B fill the stage, C is held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h00A1; in_ctrl = 8'h01;
    tick();
    chk_both("bp A", 1'b1, 8'h01, 2'd1, 1'b1);
    chk_stall("bp A", 0, 0);
    in_data = 16'h00B2; in_ctrl = 8'h02;
    tick();
    chk_both("bp B", 1'b1, 8'h01, 2'd2, 1'b0);
    chk_data("bp B", 16'h00A1, 16'h00A1);
    chk_stall("bp B", 1, 1);
    in_data = 16'h00C3; in_ctrl = 8'h03;
    tick();
    chk_both("bp C1", 1'b1, 8'h01, 2'd2, 1'b0);
    chk_stall("bp C1", 2, 2);
    tick();
    chk_data("bp C2", 16'h00A1, 16'h00A1);
    chk_stall("bp C2", 3, 3);
    out_ready = 1'b1;
    tick();
    chk_both("bp out B", 1'b1, 8'h02, 2'd1, 1'b1);
    chk_data("bp out B", 16'h00B2, 16'h00B2);
    tick();
    chk_both("bp out C", 1'b1, 8'h03, 2'd1, 1'b1);
    chk_data("bp out C", 16'h00C3, 16'h00C3);
    in_valid = 1'b0;
    tick();
    chk_both("bp drain", 1'b0, 8'h00, 2'd0, 1'b1);
    chk_stall("bp hold", 3, 3);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk_stall("clr idle", 0, 0);

    // Flush while FULL with ctrl=FF; pending input is offered but not accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h00D4; in_ctrl = 8'hFF;
    tick();
    in_data = 16'h00E5;
    tick();
    chk_both("fl full", 1'b1, 8'hFF, 2'd2, 1'b0);
    in_data = 16'h00F6;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_both("fl full after", 1'b0, 8'h00, 2'd0, 1'b1);
    chk_data("fl full after", 16'h00D4, 16'h0000);
    chk_stall("fl full", 2, 2);
    tick();
    chk_both("fl full idle", 1'b0, 8'h00, 2'd0, 1'b1);

    // Skid entry must have been killed: next push is G, not E
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 16'h0047; in_ctrl = 8'h47;
    tick();
    chk_both("fl G", 1'b1, 8'h47, 2'd1, 1'b1);
    chk_data("fl G", 16'h0047, 16'h0047);

    // Flush in ONE with a simultaneous accepted input H, which is lost
    out_ready = 1'b0;
    in_data = 16'h0048; in_ctrl = 8'hFF;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_both("fl one", 1'b0, 8'h00, 2'd0, 1'b1);
    chk_data("fl one", 16'h0047, 16'h0000);
    chk_stall("fl one", 3, 3);
    tick();
    chk_both("fl one lost", 1'b0, 8'h00, 2'd0, 1'b1);

    // Stall saturation and clear-over-increment
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h004A; in_ctrl = 8'h4A;
    tick();
    in_valid = 1'b0;
    chk_stall("sat start", 0, 0);
    for (int i = 0; i < 10; i++) tick();
    chk_stall("sat 10", 10, 7);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk_stall("clr while stalling", 0, 0);
    tick();
    chk_stall("count after clr", 1, 1);

    // Build FULL with stall_cnt=5, then asynchronous reset between edges
    in_valid = 1'b1;
    in_data = 16'h004B; in_ctrl = 8'h4B;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_both("pre-reset", 1'b1, 8'h4A, 2'd2, 1'b0);
    chk_stall("pre-reset", 5, 5);
    #2 rst = 1'b0;
    #1;
    chk_both("async reset", 1'b0, 8'h00, 2'd0, 1'b1);
    chk_data("async reset", 16'h0000, 16'h0000);
    chk_stall("async reset", 0, 0);
    tick();
    #3 rst = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 16'h000A; in_ctrl = 8'h5A;
    tick();
    chk_both("post-reset push", 1'b1, 8'h5A, 2'd1, 1'b1);
    chk_data("post-reset push", 16'h000A, 16'h000A);
    in_valid = 1'b0;
    tick();
    chk_both("post-reset drain", 1'b0, 8'h00, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
